// File: rtl/cbus_arbiter_if.sv
// CBus request/response types and the bundled port set of the round-robin CBus arbiter.
// The arbiter uses the slave view; requesters and downstream sit on the master view.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Burst length encodings: beats = len + 1.
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

endpackage

interface cbus_arbiter_if #(
    parameter int unsigned NUM_INPUTS = 2
);
    import cbus_pkg::*;

    cbus_req_t  ireqs  [NUM_INPUTS];
    cbus_resp_t iresps [NUM_INPUTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave (
        input  ireqs,
        output iresps,
        output oreq,
        input  oresp
    );

    modport master (
        output ireqs,
        input  iresps,
        input  oreq,
        output oresp
    );

endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus master port among NUM_INPUTS requesters.
// The grant is registered and held for a whole transaction, up to the ready&&last beat.
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2
) (
    input logic           clk,
    input logic           resetn,
    cbus_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_INPUTS);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] index_q, index_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;

    logic            found;
    logic [IdxW-1:0] pick;

    // Scan last_grant+1 .. last_grant+N so the most recent owner is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            int unsigned cand;
            cand = (32'(last_grant_q) + k) % NUM_INPUTS;
            if (!found && bus.ireqs[IdxW'(cand)].valid) begin
                found = 1'b1;
                pick  = IdxW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        last_grant_d = last_grant_q;
        bus.oreq     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.iresps[i] = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    index_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                bus.oreq               = bus.ireqs[index_q];
                bus.iresps[index_q]    = bus.oresp;
                if (bus.oresp.ready && bus.oresp.last) begin
                    state_d      = StIdle;
                    last_grant_d = index_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            index_q      <= '0;
            last_grant_q <= IdxW'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed and randomized bench for cbus_arbiter with two requesters, checked against a
// transaction-level round-robin model.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;

    logic clk;
    logic resetn;

    cbus_req_t  req_drv [N];
    cbus_resp_t rsp_drv;

    cbus_arbiter_if #(.NUM_INPUTS(N)) bus ();

    assign bus.ireqs = req_drv;
    assign bus.oresp = rsp_drv;

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner of the bus (if any) and the round-robin pointer.
    bit m_known = 0;
    bit m_busy  = 0;
    int m_owner = 0;
    int m_last  = N - 1;
    bit done [N];
    int ds_beats = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic v, input logic w, input logic [31:0] a,
                                         input logic [3:0] l, input logic [3:0] s,
                                         input logic [31:0] d);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = w;
        r.size     = 3'd2;
        r.addr     = a;
        r.strobe   = s;
        r.data     = d;
        r.len      = l;
        return r;
    endfunction

    task automatic settle();
        cbus_req_t  er;
        cbus_resp_t ers;
        @(negedge clk);
        if (m_known) begin
            er = m_busy ? req_drv[m_owner] : '0;
            chk("oreq", 128'(bus.oreq), 128'(er));
            for (int i = 0; i < N; i++) begin
                ers = (m_busy && m_owner == i) ? rsp_drv : '0;
                chk($sformatf("iresps[%0d]", i), 128'(bus.iresps[i]), 128'(ers));
            end
        end
    endtask

    task automatic adv();
        for (int i = 0; i < N; i++) begin
            done[i] = resetn && m_known && m_busy && m_owner == i && rsp_drv.ready
                      && rsp_drv.last;
        end
        if (!resetn) begin
            m_known = 1;
            m_busy  = 0;
            m_last  = N - 1;
        end else if (m_known) begin
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!m_busy && req_drv[c].valid) begin
                        m_busy  = 1;
                        m_owner = c;
                    end
                end
            end else if (rsp_drv.ready && rsp_drv.last) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_drv[i] = '0;
            done[i]    = 0;
        end
        rsp_drv = '0;
        step();
        step();
        chk("reset_oreq_valid", 128'(bus.oreq.valid), 128'(1'b0));
        resetn = 1'b1;

        // Single read on input 1.
        req_drv[1] = mk_req(1'b1, 1'b0, 32'h8000_0010, MLEN1, 4'h0, 32'h0);
        step();
        settle();
        chk("t1_latency_valid", 128'(bus.oreq.valid), 128'(1'b1));
        chk("t1_addr", 128'(bus.oreq.addr), 128'(32'h8000_0010));
        adv();
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'hDEADBEEF};
        settle();
        chk("t1_resp_data", 128'(bus.iresps[1].data), 128'(32'hDEADBEEF));
        chk("t1_resp_ready", 128'(bus.iresps[1].ready), 128'(1'b1));
        chk("t1_other_zero", 128'(bus.iresps[0]), 128'(0));
        adv();
        req_drv[1] = '0;
        rsp_drv    = '0;
        settle();
        chk("t1_release", 128'(bus.oreq.valid), 128'(1'b0));
        adv();

        // Simultaneous requests after reset: 0 wins, 1 follows two cycles after the last beat.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        req_drv[0] = mk_req(1'b1, 1'b0, A0, MLEN1, 4'h0, 32'h0);
        req_drv[1] = mk_req(1'b1, 1'b0, A1, MLEN1, 4'h0, 32'h0);
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0000_0A0A};
        settle();
        chk("t2_first", 128'(bus.oreq.addr), 128'(A0));
        adv();
        req_drv[0] = '0;
        rsp_drv    = '0;
        settle();
        chk("t2_gap", 128'(bus.oreq.valid), 128'(1'b0));
        adv();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0000_0B0B};
        settle();
        chk("t2_second", 128'(bus.oreq.addr), 128'(A1));
        adv();
        req_drv[1] = '0;
        rsp_drv    = '0;
        step();

        // Fairness: both continuously valid, eight single-beat transactions.
        req_drv[0] = mk_req(1'b1, 1'b0, A0, MLEN1, 4'h0, 32'h0);
        req_drv[1] = mk_req(1'b1, 1'b0, A1, MLEN1, 4'h0, 32'h0);
        for (int t = 0; t < 8; t++) begin
            rsp_drv = '0;
            step();
            rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'(t)};
            settle();
            chk($sformatf("t3_order%0d", t), 128'(bus.oreq.addr), 128'((t % 2 == 0) ? A0 : A1));
            adv();
        end
        req_drv[0] = '0;
        req_drv[1] = '0;
        rsp_drv    = '0;
        step();

        // Burst hold: four-beat write on 0, input 1 arrives during beat 2.
        req_drv[0] = mk_req(1'b1, 1'b1, A0, MLEN4, 4'hF, 32'h1234_5678);
        step();
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) req_drv[1] = mk_req(1'b1, 1'b0, A1, MLEN1, 4'h0, 32'h0);
            rsp_drv = '{ready: 1'b1, last: (b == 4), data: 32'h0};
            settle();
            chk($sformatf("t4_owner_b%0d", b), 128'(bus.oreq.addr), 128'(A0));
            chk($sformatf("t4_hold1_b%0d", b), 128'(bus.iresps[1].ready), 128'(1'b0));
            adv();
        end
        req_drv[0] = '0;
        rsp_drv    = '0;
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        settle();
        chk("t4_next_grant", 128'(bus.oreq.addr), 128'(A1));
        adv();
        req_drv[1] = '0;
        rsp_drv    = '0;
        step();

        // Reset mid-burst: pointer left at 0 beforehand, so only reset restores 0's priority.
        req_drv[0] = mk_req(1'b1, 1'b0, A0, MLEN1, 4'h0, 32'h0);
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        step();
        req_drv[0] = '0;
        rsp_drv    = '0;
        step();
        req_drv[1] = mk_req(1'b1, 1'b0, A1, MLEN4, 4'h0, 32'h0);
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b0, data: 32'h5555_0000};
        step();
        step();
        resetn  = 1'b0;
        rsp_drv = '0;
        step();
        resetn     = 1'b1;
        req_drv[1] = '0;
        settle();
        chk("t5_oreq_zero", 128'(bus.oreq), 128'(0));
        chk("t5_resp1_zero", 128'(bus.iresps[1]), 128'(0));
        adv();
        req_drv[0] = mk_req(1'b1, 1'b0, A0, MLEN1, 4'h0, 32'h0);
        req_drv[1] = mk_req(1'b1, 1'b0, A1, MLEN1, 4'h0, 32'h0);
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        settle();
        chk("t5_priority0", 128'(bus.oreq.addr), 128'(A0));
        adv();
        req_drv[0] = '0;
        rsp_drv    = '0;
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        step();
        req_drv[1] = '0;
        rsp_drv    = '0;
        step();

        // Stray response while idle.
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_F00D};
        step();
        settle();
        chk("t6_stray0", 128'(bus.iresps[0]), 128'(0));
        chk("t6_stray1", 128'(bus.iresps[1]), 128'(0));
        adv();
        rsp_drv    = '0;
        req_drv[0] = mk_req(1'b1, 1'b0, A0, MLEN1, 4'h0, 32'h0);
        step();
        rsp_drv = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        settle();
        chk("t6_still_idle_latency", 128'(bus.oreq.valid), 128'(1'b1));
        adv();
        req_drv[0] = '0;
        rsp_drv    = '0;
        step();

        // Randomized traffic with a downstream that counts beats per burst.
        for (int i = 0; i < N; i++) done[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    req_drv[i] = '0;
                end else if (!req_drv[i].valid && ($urandom % 3 == 0)) begin
                    req_drv[i] = mk_req(1'b1, 1'($urandom % 2), {i[0], 31'($urandom)},
                                        4'($urandom % 4), 4'($urandom), $urandom);
                end
            end
            #1;
            if (bus.oreq.valid && ($urandom % 3 != 0)) begin
                ds_beats++;
                rsp_drv.ready = 1'b1;
                rsp_drv.last  = (ds_beats == int'(bus.oreq.len) + 1);
                rsp_drv.data  = $urandom;
                if (rsp_drv.last) ds_beats = 0;
            end else begin
                rsp_drv = '0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter sharing one CBus master port among `NUM_INPUTS` CBus requesters, such as the instruction-side and data-side bus converters. It sits between the converters and the memory/uncached interconnect. It grants one requester at a time and holds the grant for the whole transaction, through the beat with `last`. Request fields pass through combinationally while granted. Only the grant is registered.

## Interface
- `NUM_INPUTS`, default 2: number of requesters; must be ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `ireqs`  in  `NUM_INPUTS` × `cbus_req_t`: requester buses.
  - Fields: valid, is_write, size, addr, strobe, data, len.
- `iresps`  out  `NUM_INPUTS` × `cbus_resp_t`: per-requester response.
  - Fields: ready, last, data.
- `oreq`  out  `cbus_req_t`: shared request to downstream.
- `oresp`  in  `cbus_resp_t`: downstream response.

## Operation
- State machine: IDLE, BUSY. Registers:
  - `state`
  - `index`: granted requester, width clog2(`NUM_INPUTS`)
  - `last_grant`: round-robin pointer
- IDLE:
  - `oreq` is all-zero.
  - Every `iresps[i]` is all-zero.
  - If any `ireqs[i].valid` = 1, pick the first valid i scanning `last_grant`+1, `last_grant`+2, … modulo `NUM_INPUTS`.
  - Latch that i into `index` and go to BUSY.
  - No valid request: stay IDLE.
- BUSY:
  - `oreq` = `ireqs[index]`: every field verbatim, including valid.
  - `iresps[index]` = `oresp`.
  - Every other `iresps[j]` is all-zero.
  - On a cycle with `oresp.ready` && `oresp.last`:
    - that beat is delivered to the requester in the same cycle;
    - next state is IDLE;
    - `last_grant` ← `index`.
- Round-robin: the requester that just finished has lowest priority at the next arbitration. With all inputs continuously valid, grants rotate 0,1,…,N-1,0.
- Burst handling:
  - The grant is never released on `ready` without `last`.
  - Multi-beat bursts (len > MLEN1) keep the same owner for all beats.
- Requester rule: hold valid and all request fields stable from the cycle valid rises until its `ready`&&`last` beat.
- Protocol violation (granted requester drops valid before `last`):
  - the arbiter stays BUSY and forwards the low valid;
  - it returns to IDLE only on `ready`&&`last`;
  - no other requester is granted meanwhile.
- Non-granted requesters see ready=0, so they hold their requests; no request is lost or duplicated.
- `oresp` is ignored in IDLE. A stray ready/last in IDLE has no effect.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - state=IDLE, `index`=0, `last_grant`=`NUM_INPUTS`-1, so input 0 has top priority after reset;
  - from the next cycle, `oreq` and all `iresps` are all-zero.
- Reset mid-BUSY: abandons the transaction immediately. Downstream shares `resetn` and is reset in the same cycle.
- Arbitration latency:
  - request valid in cycle t (arbiter IDLE) → `oreq.valid`=1 in cycle t+1;
  - fixed 1 cycle, no combinational path from `ireqs[*].valid` to the grant.
- Release:
  - `ready`&&`last` in cycle k → IDLE in cycle k+1, with `oreq` zero in k+1;
  - the next grant is visible at the earliest in k+2.
- Bus occupancy: minimum transaction is 3 cycles (arbitrate, one beat, idle gap).
- Simultaneous events:
  - several valid in the same IDLE cycle: the round-robin winner is granted;
  - a new request arriving during BUSY waits; it is not pre-empted or queued beyond its own held valid.
- No combinational path from `ireqs` to `iresps`. Paths from `oresp` to `iresps` and from `ireqs` to `oreq` are combinational.

## Test plan
- Single read, `NUM_INPUTS`=2:
  - Stimulus: `ireqs[1]` valid, addr 0x8000_0010, len MLEN1, from cycle 0; downstream asserts ready+last with data 0xDEADBEEF in cycle 3.
  - Response: `oreq` mirrors `ireqs[1]` in cycles 1–3; `iresps[1]` = {1,1,0xDEADBEEF} in cycle 3; `iresps[0]` zero throughout; `oreq.valid`=0 in cycle 4.
- Post-reset simultaneous requests:
  - Stimulus: both valid in cycle 0 after reset.
  - Response: input 0 granted in cycle 1; after its last beat, input 1 is granted two cycles later.
- Round-robin fairness:
  - Stimulus: both inputs continuously valid, downstream answers each with one beat; 8 transactions.
  - Response: grant order 0,1,0,1,0,1,0,1.
- Burst hold:
  - Stimulus: `ireqs[0]` write, len MLEN4, strobe 0xF; ready in 4 beats, last on the 4th; `ireqs[1]` rises during beat 2.
  - Response: owner stays 0 for all 4 beats; `iresps[1].ready` stays 0; input 1 is granted 2 cycles after the 4th beat.
- Reset mid-burst:
  - Stimulus: `resetn`=0 for one cycle after beat 2 of a MLEN4 read.
  - Response: next cycle state IDLE, `oreq` zero, `iresps` zero; input 0 regains priority.
- Stray response in IDLE:
  - Stimulus: `oresp` ready=1, last=1 with no requests.
  - Response: all `iresps` remain zero; state remains IDLE.
